// File: rtl/ex_pkg.sv
// Shared types and op codes for the execute-stage dispatcher.
// Op codes are the values carried on in_mode and forwarded to the selected unit.
package ex_pkg;

  typedef enum logic {
    UNIT_ALU = 1'b0,
    UNIT_FPU = 1'b1
  } unit_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_MUL = 4'b0101;
  localparam logic [3:0] ALU_DIV = 4'b0110;

  localparam logic [3:0] FPU_FADD = 4'b0000;
  localparam logic [3:0] FPU_FSUB = 4'b0001;
  localparam logic [3:0] FPU_FMUL = 4'b0010;
  localparam logic [3:0] FPU_FDIV = 4'b0011;

  function automatic logic mode_legal(input unit_e unit, input logic [3:0] mode);
    if (unit == UNIT_ALU) return (mode <= ALU_DIV);
    else                  return (mode <= FPU_FDIV);
  endfunction

endpackage

// File: rtl/ex_dispatch.sv
// Issue/collect stage in front of the integer ALU and the FPU: one op in flight.
// Optional feature: define DIV_ZERO_TRAP_EN to reject divides by zero without issuing them.
module ex_dispatch
  import ex_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int FLEN    = 32,
  parameter int ALU_LAT = 1,
  parameter int FPU_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_unit,
  input  logic [3:0]      in_mode,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_mode,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_zf,
  input  logic            alu_nf,
  output logic [FLEN-1:0] fpu_a,
  output logic [FLEN-1:0] fpu_b,
  output logic [3:0]      fpu_mode,
  input  logic [FLEN-1:0] fpu_y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            out_zf,
  output logic            out_nf,
  output logic            out_err
);

  localparam int MAX_LAT = (ALU_LAT > FPU_LAT) ? ALU_LAT : FPU_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          sel_fpu_q;
  logic          illegal_q;
  logic          flag_ld_q;
  unit_e         unit_in;
  logic          legal;
  logic          trap;

  assign unit_in   = unit_e'(in_unit);
  assign legal     = mode_legal(unit_in, in_mode);
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);

  // A trapped divide never reaches a unit and completes in a single edge.
  always_comb begin
    trap = 1'b0;
`ifdef DIV_ZERO_TRAP_EN
    if (unit_in == UNIT_ALU)
      trap = (in_mode == ALU_DIV) && (in_b == '0);
    else
      trap = (in_mode == FPU_FDIV) && (in_b[FLEN-2:0] == '0);
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = trap ? S_DONE : S_WAIT;
      S_WAIT: if (cnt_q == '0) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      sel_fpu_q <= 1'b0;
      illegal_q <= 1'b0;
      flag_ld_q <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_mode  <= '0;
      fpu_a     <= '0;
      fpu_b     <= '0;
      fpu_mode  <= '0;
      out_data  <= '0;
      out_zf    <= 1'b0;
      out_nf    <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            // Only the selected, legal, non-trapped unit sees the operands.
            alu_a     <= '0;
            alu_b     <= '0;
            alu_mode  <= '0;
            fpu_a     <= '0;
            fpu_b     <= '0;
            fpu_mode  <= '0;
            if (legal && !trap) begin
              if (unit_in == UNIT_ALU) begin
                alu_a    <= in_a;
                alu_b    <= in_b;
                alu_mode <= in_mode;
              end else begin
                fpu_a    <= in_a[FLEN-1:0];
                fpu_b    <= in_b[FLEN-1:0];
                fpu_mode <= in_mode;
              end
            end
            cnt_q     <= (unit_in == UNIT_FPU) ? CW'(FPU_LAT - 1) : CW'(ALU_LAT - 1);
            sel_fpu_q <= (unit_in == UNIT_FPU);
            illegal_q <= !legal;
            flag_ld_q <= (unit_in == UNIT_ALU) && (in_mode == ALU_SUB);
            out_data  <= '0;
            out_err   <= trap;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            if (illegal_q)      out_data <= '0;
            else if (sel_fpu_q) out_data <= {{(XLEN-FLEN){1'b0}}, fpu_y};
            else                out_data <= alu_out;
            if (flag_ld_q) begin
              out_zf <= alu_zf;
              out_nf <= alu_nf;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_data <= '0;
            out_err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_dispatch.sv
// Self-checking bench for ex_dispatch with behavioural ALU/FPU stand-ins.
// Expected results come from a transaction-level model of each op.
module tb_ex_dispatch;

  localparam int XLEN    = 64;
  localparam int FLEN    = 32;
  localparam int ALU_LAT = 1;
  localparam int FPU_LAT = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic            in_unit;
  logic [3:0]      in_mode;
  logic [XLEN-1:0] in_a, in_b;
  logic [XLEN-1:0] alu_a, alu_b, alu_out;
  logic [3:0]      alu_mode, fpu_mode;
  logic            alu_zf, alu_nf;
  logic [FLEN-1:0] fpu_a, fpu_b, fpu_y;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_data;
  logic            out_zf, out_nf, out_err;

  int n_checks = 0;
  int n_fails  = 0;
  logic zf_m = 1'b0;
  logic nf_m = 1'b0;

  always #5 clk = ~clk;

  ex_dispatch #(.XLEN(XLEN), .FLEN(FLEN), .ALU_LAT(ALU_LAT), .FPU_LAT(FPU_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_unit(in_unit),
    .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .alu_a(alu_a), .alu_b(alu_b),
    .alu_mode(alu_mode), .alu_out(alu_out), .alu_zf(alu_zf), .alu_nf(alu_nf),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_mode(fpu_mode), .fpu_y(fpu_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zf(out_zf), .out_nf(out_nf), .out_err(out_err)
  );

  function automatic logic [63:0] alu_fn(input logic [3:0] m, input logic [63:0] a, input logic [63:0] b);
    case (m)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a ^ b;
      4'd3: return a + b;
      4'd4: return a - b;
      4'd5: return a * b;
      4'd6: return (b == 0) ? '1 : a / b;
      default: return '0;
    endcase
  endfunction

  // Truncating single-precision multiply, exact for the simple normal values used here.
  function automatic logic [31:0] fmul_fn(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127 + {9'd0, p[47]};
    m = p[47] ? p[46:24] : p[45:23];
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  function automatic logic [31:0] fpu_fn(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b);
    case (m)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return fmul_fn(a, b);
      4'd3: return a ^ {b[15:0], b[31:16]};
      default: return '0;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_mode, alu_a, alu_b);
  assign alu_zf  = (alu_out == '0);
  assign alu_nf  = alu_out[XLEN-1];
  assign fpu_y   = fpu_fn(fpu_mode, fpu_a, fpu_b);

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one op, checks unit drive, latency, result, flags and the writeback handshake.
  task automatic applyStimulus(input logic unit, input logic [3:0] mode,
                               input logic [63:0] a, input logic [63:0] b, input int hold);
    logic        legal, trap, drive_alu, drive_fpu;
    logic [63:0] exp_data, held;
    int          exp_edges, edges;
    legal = unit ? (mode <= 4'd3) : (mode <= 4'd6);
    trap  = 1'b0;
`ifdef DIV_ZERO_TRAP_EN
    trap = unit ? (mode == 4'd3 && b[30:0] == 0) : (mode == 4'd6 && b == 0);
`endif
    drive_alu = !unit && legal && !trap;
    drive_fpu = unit && legal && !trap;
    if (!legal || trap) exp_data = '0;
    else if (unit)      exp_data = {32'd0, fpu_fn(mode, a[31:0], b[31:0])};
    else                exp_data = alu_fn(mode, a, b);
    if (!unit && mode == 4'd4) begin
      zf_m = (exp_data == 0);
      nf_m = exp_data[63];
    end
    exp_edges = trap ? 1 : ((unit ? FPU_LAT : ALU_LAT) + 1);

    @(negedge clk);
    checkOutput("in_ready_idle", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; in_unit = unit; in_mode = mode; in_a = a; in_b = b;
    out_ready = 1'b1;
    @(posedge clk);
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
      if (edges == 1) begin
        in_valid = 1'b0;
        checkOutput("in_ready_busy", {63'd0, in_ready}, 64'd0);
        checkOutput("alu_mode", {60'd0, alu_mode}, drive_alu ? {60'd0, mode} : 64'd0);
        checkOutput("alu_a", alu_a, drive_alu ? a : 64'd0);
        checkOutput("alu_b", alu_b, drive_alu ? b : 64'd0);
        checkOutput("fpu_mode", {60'd0, fpu_mode}, drive_fpu ? {60'd0, mode} : 64'd0);
        checkOutput("fpu_a", {32'd0, fpu_a}, drive_fpu ? {32'd0, a[31:0]} : 64'd0);
        checkOutput("fpu_b", {32'd0, fpu_b}, drive_fpu ? {32'd0, b[31:0]} : 64'd0);
      end
      if (out_valid && hold > 0) out_ready = 1'b0;
    end while (!out_valid && edges < 20);
    checkOutput("latency", 64'(edges), 64'(exp_edges));
    checkOutput("out_data", out_data, exp_data);
    checkOutput("out_err", {63'd0, out_err}, {63'd0, trap});
    checkOutput("out_zf", {63'd0, out_zf}, {63'd0, zf_m});
    checkOutput("out_nf", {63'd0, out_nf}, {63'd0, nf_m});
    if (hold > 0) begin
      held = out_data;
      in_valid = 1'b1; in_unit = ~unit; in_mode = 4'd1; in_a = ~a; in_b = ~b;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        checkOutput("hold_valid", {63'd0, out_valid}, 64'd1);
        checkOutput("hold_data", out_data, held);
        checkOutput("hold_in_ready", {63'd0, in_ready}, 64'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    checkOutput("valid_drop", {63'd0, out_valid}, 64'd0);
    checkOutput("in_ready_back", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] ra, rb;
    int seen;
    rst = 1'b1; in_valid = 1'b1; in_unit = 1'b0; in_mode = 4'd3;
    in_a = 64'd1; in_b = 64'd2; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_out_data", out_data, 64'd0);
    checkOutput("rst_alu_mode", {60'd0, alu_mode}, 64'd0);
    checkOutput("rst_fpu_a", {32'd0, fpu_a}, 64'd0);
    checkOutput("rst_flags", {61'd0, out_zf, out_nf, out_err}, 64'd0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    $display("[TB] directed ops");
    applyStimulus(1'b0, 4'd3, 64'd5, 64'd7, 0);
    applyStimulus(1'b0, 4'd4, 64'd3, 64'd3, 0);
    applyStimulus(1'b0, 4'd0, 64'hF, 64'd1, 0);
    applyStimulus(1'b1, 4'd2, 64'h4000_0000, 64'h4040_0000, 0);
    checkOutput("fmul_known", {32'd0, fmul_fn(32'h4000_0000, 32'h4040_0000)}, 64'h40C0_0000);
    applyStimulus(1'b0, 4'd2, 64'hDEAD_BEEF_0123_4567, 64'h0F0F_0F0F_F0F0_F0F0, 10);
    applyStimulus(1'b0, 4'd4, 64'd1, 64'd2, 0);
    applyStimulus(1'b0, 4'd6, 64'd100, 64'd0, 0);
    applyStimulus(1'b1, 4'd3, 64'h3F80_0000, 64'h8000_0000, 0);
    applyStimulus(1'b0, 4'd9, 64'd8, 64'd9, 0);
    applyStimulus(1'b1, 4'd5, 64'd8, 64'd9, 1);

    $display("[TB] reset during an FPU op");
    @(negedge clk);
    in_valid = 1'b1; in_unit = 1'b1; in_mode = 4'd0; in_a = 64'h1234; in_b = 64'h5678;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    zf_m = 1'b0; nf_m = 1'b0;
    checkOutput("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_mid_fpu_a", {32'd0, fpu_a}, 64'd0);
    checkOutput("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("rst_mid_no_result", 64'(seen), 64'd0);

    $display("[TB] random ops");
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), ra, rb,
                    $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
